// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   bits()     : address width for a given register count (never below 1)
//   sliceLsb() : LSB of lane idx within a packed multi-port bus
//   Def*       : default geometry constants
package regfile_pkg;

   localparam int unsigned DefWordLen   = 32;
   localparam int unsigned DefWordCount = 32;
   localparam int unsigned DefNR        = 3;
   localparam int unsigned DefNW        = 2;

   function automatic int unsigned bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned sliceLsb(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

endpackage

// File: rtl/multiport_regfile_if.sv
// Bus bundle for the register file: write ports, alloc port and read ports.
//   master : issue/writeback side, drives addresses, data and enables
//   slave  : the register file, returns read data and busy flags
interface multiport_regfile_if
   import regfile_pkg::*;
#(
   parameter int unsigned WordLen   = DefWordLen,
   parameter int unsigned WordCount = DefWordCount,
   parameter int unsigned NR        = DefNR,
   parameter int unsigned NW        = DefNW
);
   localparam int unsigned AW = bits(WordCount);

   logic [NW-1:0]         wr_en;
   logic [NW*AW-1:0]      wr_addr;
   logic [NW*WordLen-1:0] wr_data;
   logic                  alloc_en;
   logic [AW-1:0]         alloc_addr;
   logic [NR*AW-1:0]      rd_addr;
   logic [NR*WordLen-1:0] rd_data;
   logic [NR-1:0]         rd_busy;

   modport master (
      output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
      output rd_data, rd_busy
   );

endinterface

// File: rtl/regfile_bypass_mux.sv
// One read port of the register file.
//   rst       : bypass is suppressed while high
//   rdAddr    : register being read
//   wrEn/wrAddr/wrData : this cycle's packed write ports (bypass sources)
//   arrayData/arrayBusy: stored value and busy bit of rdAddr
//   rdData/rdBusy      : resolved read result
module regfile_bypass_mux
   import regfile_pkg::*;
#(
   parameter int unsigned WordLen   = DefWordLen,
   parameter int unsigned WordCount = DefWordCount,
   parameter int unsigned NW        = DefNW,
   localparam int unsigned AW       = bits(WordCount)
) (
   input  logic                  rst,
   input  logic [AW-1:0]         rdAddr,
   input  logic [NW-1:0]         wrEn,
   input  logic [NW*AW-1:0]      wrAddr,
   input  logic [NW*WordLen-1:0] wrData,
   input  logic [WordLen-1:0]    arrayData,
   input  logic                  arrayBusy,
   output logic [WordLen-1:0]    rdData,
   output logic                  rdBusy
);

   always_comb begin
      rdData = arrayData;
      rdBusy = arrayBusy;
      // Ascending scan so the highest-indexed hitting port overrides earlier ones.
      for (int i = 0; i < int'(NW); i++) begin
         if (!rst && wrEn[i] && (wrAddr[sliceLsb(i, AW) +: AW] == rdAddr)) begin
            rdData = wrData[sliceLsb(i, WordLen) +: WordLen];
            rdBusy = 1'b0;
         end
      end
      // Applied last: masks both bypass hits on r0 and an unreset array entry.
      if (rdAddr == '0) begin
         rdData = '0;
         rdBusy = 1'b0;
      end
   end

endmodule

// File: rtl/multiport_regfile.sv
// Multi-port integer register file with write-through bypass and busy scoreboard.
//   clk : clock, all state updates on posedge
//   rst : synchronous active-high reset, clears data and busy bits
//   bus : slave side of multiport_regfile_if (NW write ports, one alloc port,
//         NR combinational read ports with busy flags)
module multiport_regfile
   import regfile_pkg::*;
#(
   parameter int unsigned WordLen   = DefWordLen,
   parameter int unsigned WordCount = DefWordCount,
   parameter int unsigned NR        = DefNR,
   parameter int unsigned NW        = DefNW
) (
   input logic                 clk,
   input logic                 rst,
   multiport_regfile_if.slave  bus
);

   localparam int unsigned AW = bits(WordCount);

   logic [WordLen-1:0]   regsQ [WordCount];
   logic [WordLen-1:0]   regsD [WordCount];
   logic [WordCount-1:0] busyQ;
   logic [WordCount-1:0] busyD;
   logic [AW-1:0]        wAddr;

   always_comb begin
      regsD = regsQ;
      busyD = busyQ;
      wAddr = '0;
      // Later ports overwrite earlier ones: highest index wins on conflict.
      for (int i = 0; i < int'(NW); i++) begin
         wAddr = bus.wr_addr[sliceLsb(i, AW) +: AW];
         if (bus.wr_en[i] && (wAddr != '0)) begin
            regsD[wAddr] = bus.wr_data[sliceLsb(i, WordLen) +: WordLen];
            busyD[wAddr] = 1'b0;
         end
      end
      // Alloc after writes: a newly issued producer outranks a completing one.
      if (bus.alloc_en && (bus.alloc_addr != '0)) begin
         busyD[bus.alloc_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regsQ <= '{default: '0};
         busyQ <= '0;
      end else begin
         regsQ <= regsD;
         busyQ <= busyD;
      end
   end

   for (genvar j = 0; j < int'(NR); j++) begin : gRead
      logic [AW-1:0] rAddr;
      assign rAddr = bus.rd_addr[sliceLsb(j, AW) +: AW];

      regfile_bypass_mux #(
         .WordLen   (WordLen),
         .WordCount (WordCount),
         .NW        (NW)
      ) uMux (
         .rst       (rst),
         .rdAddr    (rAddr),
         .wrEn      (bus.wr_en),
         .wrAddr    (bus.wr_addr),
         .wrData    (bus.wr_data),
         .arrayData (regsQ[rAddr]),
         .arrayBusy (busyQ[rAddr]),
         .rdData    (bus.rd_data[sliceLsb(j, WordLen) +: WordLen]),
         .rdBusy    (bus.rd_busy[j])
      );
   end

endmodule

// File: tb/tb_multiport_regfile.sv
// Directed checks on the default geometry plus a randomised sweep of a
// 16-bit / 8-entry / 4-read / 3-write instance against a reference model.
module tb_multiport_regfile;

   logic clk = 1'b0;
   logic rstA;
   logic rstB;
   int   nChecks = 0;
   int   nPass   = 0;

   always #5 clk = ~clk;

   multiport_regfile_if #(.WordLen(32), .WordCount(32), .NR(3), .NW(2)) busA ();
   multiport_regfile_if #(.WordLen(16), .WordCount(8),  .NR(4), .NW(3)) busB ();

   multiport_regfile #(.WordLen(32), .WordCount(32), .NR(3), .NW(2)) dutA (
      .clk (clk),
      .rst (rstA),
      .bus (busA.slave)
   );

   multiport_regfile #(.WordLen(16), .WordCount(8), .NR(4), .NW(3)) dutB (
      .clk (clk),
      .rst (rstB),
      .bus (busB.slave)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Leave the posedge behind before touching inputs.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idleA();
      busA.wr_en      = '0;
      busA.wr_addr    = '0;
      busA.wr_data    = '0;
      busA.alloc_en   = 1'b0;
      busA.alloc_addr = '0;
   endtask

   // Reference model state for the sweep instance.
   logic [15:0] mRegs [8];
   logic [7:0]  mBusy;
   logic [63:0] expD;
   logic [3:0]  expB;

   task automatic modelRead();
      logic [2:0]  a;
      logic [15:0] d;
      logic        b;
      for (int j = 0; j < 4; j++) begin
         a = busB.rd_addr[j*3 +: 3];
         d = mRegs[a];
         b = mBusy[a];
         for (int i = 0; i < 3; i++) begin
            if (!rstB && busB.wr_en[i] && busB.wr_addr[i*3 +: 3] == a) begin
               d = busB.wr_data[i*16 +: 16];
               b = 1'b0;
            end
         end
         if (a == 3'd0) begin
            d = '0;
            b = 1'b0;
         end
         expD[j*16 +: 16] = d;
         expB[j]          = b;
      end
   endtask

   task automatic modelClock();
      logic [2:0] a;
      if (rstB) begin
         for (int k = 0; k < 8; k++) mRegs[k] = '0;
         mBusy = '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            a = busB.wr_addr[i*3 +: 3];
            if (busB.wr_en[i] && a != 3'd0) begin
               mRegs[a] = busB.wr_data[i*16 +: 16];
               mBusy[a] = 1'b0;
            end
         end
         if (busB.alloc_en && busB.alloc_addr != 3'd0) mBusy[busB.alloc_addr] = 1'b1;
      end
   endtask

   initial begin
      rstA = 1'b1;
      rstB = 1'b1;
      idleA();
      busA.rd_addr    = '0;
      busB.wr_en      = '0;
      busB.wr_addr    = '0;
      busB.wr_data    = '0;
      busB.alloc_en   = 1'b0;
      busB.alloc_addr = '0;
      busB.rd_addr    = '0;
      step();

      // Reset state
      rstA = 1'b0;
      busA.rd_addr = {5'd3, 5'd2, 5'd1};
      #1;
      check("reset_data", 128'(busA.rd_data), 128'd0);
      check("reset_busy", 128'(busA.rd_busy), 128'd0);

      // Fill r1..r31 with 0x1000+n, two per cycle
      for (int i = 1; i <= 31; i += 2) begin
         busA.wr_en   = (i + 1 <= 31) ? 2'b11 : 2'b01;
         busA.wr_addr = {5'(i + 1), 5'(i)};
         busA.wr_data = {32'(32'h1000 + i + 1), 32'(32'h1000 + i)};
         step();
      end
      idleA();
      busA.rd_addr = {5'd2, 5'd31, 5'd17};
      #1;
      check("fill_data", 128'(busA.rd_data), 128'({32'h1002, 32'h101F, 32'h1011}));

      // Reset cycle with a write and alloc: bypass off, everything discarded
      rstA = 1'b1;
      busA.wr_en      = 2'b01;
      busA.wr_addr    = {5'd0, 5'd4};
      busA.wr_data    = {32'd0, 32'h0000AAAA};
      busA.alloc_en   = 1'b1;
      busA.alloc_addr = 5'd6;
      busA.rd_addr    = {5'd6, 5'd17, 5'd4};
      #1;
      check("rst_no_bypass", 128'(busA.rd_data[31:0]), 128'h1004);
      step();
      rstA = 1'b0;
      idleA();
      #1;
      check("post_rst_data", 128'(busA.rd_data), 128'd0);
      check("post_rst_busy", 128'(busA.rd_busy), 128'd0);

      // Same-cycle bypass, then array read
      busA.wr_en   = 2'b01;
      busA.wr_addr = {5'd0, 5'd5};
      busA.wr_data = {32'd0, 32'hDEADBEEF};
      busA.rd_addr = {5'd0, 5'd0, 5'd5};
      #1;
      check("bypass_data", 128'(busA.rd_data[31:0]), 128'hDEADBEEF);
      check("bypass_busy", 128'(busA.rd_busy), 128'd0);
      step();
      idleA();
      #1;
      check("array_data", 128'(busA.rd_data[31:0]), 128'hDEADBEEF);

      // Write conflict: port 1 wins
      busA.wr_en   = 2'b11;
      busA.wr_addr = {5'd7, 5'd7};
      busA.wr_data = {32'h22, 32'h11};
      busA.rd_addr = {5'd0, 5'd7, 5'd5};
      #1;
      check("conflict_bypass", 128'(busA.rd_data[63:32]), 128'h22);
      step();
      idleA();
      #1;
      check("conflict_array", 128'(busA.rd_data[63:0]), 128'({32'h22, 32'hDEADBEEF}));

      // Register 0 ignores writes and allocs
      busA.wr_en      = 2'b11;
      busA.wr_addr    = {5'd0, 5'd0};
      busA.wr_data    = {32'h00001234, 32'hFFFFFFFF};
      busA.alloc_en   = 1'b1;
      busA.alloc_addr = 5'd0;
      busA.rd_addr    = {5'd0, 5'd0, 5'd0};
      #1;
      check("r0_bypass_data", 128'(busA.rd_data), 128'd0);
      check("r0_bypass_busy", 128'(busA.rd_busy), 128'd0);
      step();
      idleA();
      #1;
      check("r0_array_data", 128'(busA.rd_data), 128'd0);
      check("r0_array_busy", 128'(busA.rd_busy), 128'd0);

      // Scoreboard
      busA.alloc_en   = 1'b1;
      busA.alloc_addr = 5'd9;
      busA.rd_addr    = {5'd0, 5'd0, 5'd9};
      #1;
      check("alloc_same_cycle", 128'(busA.rd_busy[0]), 128'd0);
      step();
      idleA();
      #1;
      check("alloc_next_cycle", 128'(busA.rd_busy[0]), 128'd1);
      busA.wr_en   = 2'b10;
      busA.wr_addr = {5'd9, 5'd0};
      busA.wr_data = {32'h42, 32'd0};
      #1;
      check("wr_clears_bypass", 128'({busA.rd_busy[0], busA.rd_data[31:0]}), 128'({1'b0, 32'h42}));
      step();
      idleA();
      #1;
      check("wr_clears_array", 128'({busA.rd_busy[0], busA.rd_data[31:0]}), 128'({1'b0, 32'h42}));
      busA.wr_en      = 2'b01;
      busA.wr_addr    = {5'd0, 5'd9};
      busA.wr_data    = {32'd0, 32'h77};
      busA.alloc_en   = 1'b1;
      busA.alloc_addr = 5'd9;
      #1;
      check("alloc_wr_bypass", 128'({busA.rd_busy[0], busA.rd_data[31:0]}), 128'({1'b0, 32'h77}));
      step();
      idleA();
      #1;
      check("alloc_wins", 128'({busA.rd_busy[0], busA.rd_data[31:0]}), 128'({1'b1, 32'h77}));

      // Mid-operation reset drops busy state and data
      rstA = 1'b1;
      step();
      rstA = 1'b0;
      #1;
      check("midop_rst", 128'({busA.rd_busy[0], busA.rd_data[31:0]}), 128'd0);

      // Randomised sweep of the small instance
      for (int k = 0; k < 8; k++) mRegs[k] = '0;
      mBusy = '0;
      rstB  = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         rstB            = ($urandom_range(63) == 0);
         busB.wr_en      = 3'($urandom());
         busB.wr_addr    = 9'($urandom());
         busB.wr_data    = 48'($urandom()) ^ (48'($urandom()) << 16);
         busB.alloc_en   = 1'($urandom());
         busB.alloc_addr = 3'($urandom());
         busB.rd_addr    = 12'($urandom());
         #1;
         modelRead();
         check("sweep_data", 128'(busB.rd_data), 128'(expD));
         check("sweep_busy", 128'(busB.rd_busy), 128'(expB));
         modelClock();
         step();
      end

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule

// File: doc/multiport_regfile.md
# multiport_regfile

Parametrised multi-port register file with write-through bypass and a per-register busy scoreboard, used as the processor's integer register file in the next pipeline generation. It provides NR combinational read ports and NW synchronous write ports. Each read port also returns a busy flag so issue logic can stall on outstanding producers. Register 0 is hardwired to zero.

## Interface
- WordLen, 32, data width in bits
- WordCount, 32, number of registers (power of two, ≥2); AW = clog2(WordCount)
- NR, 3, number of read ports (≥1)
- NW, 2, number of write ports (≥1)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous and active-high
- wr_en  in  NW  per-port write enable
- wr_addr  in  NW*AW  write addresses; port i occupies bits [i*AW +: AW]
- wr_data  in  NW*WordLen  write data; port i occupies bits [i*WordLen +: WordLen]
- alloc_en  in  1  mark a destination register busy (instruction issued)
- alloc_addr  in  AW  register to mark busy
- rd_addr  in  NR*AW  read addresses, packed the same way as wr_addr
- rd_data  out  NR*WordLen  read data
- rd_busy  out  NR  per-port busy flag

## Operation
- State: array regs[WordCount] of WordLen bits; busy vector of WordCount bits.
- Write: on posedge, when !rst, each port i with wr_en[i] and wr_addr_i≠0 loads regs[wr_addr_i] <= wr_data_i and clears busy[wr_addr_i].
- Write conflict: if several enabled ports target the same address, the highest-indexed port wins.
- Writes to address 0 are dropped. regs[0] always reads 0. busy[0] is always 0.
- Alloc: on posedge, when !rst and alloc_en and alloc_addr≠0, set busy[alloc_addr].
- Alloc and write to the same register in one cycle: busy ends up set, because alloc wins (it is a newer producer). The write data is still stored.
- Read (combinational), for each port j with address a:
  - If a=0: rd_data_j=0 and rd_busy_j=0.
  - Else, if any enabled write port targets a this cycle and !rst: rd_data_j=the winning port's wr_data and rd_busy_j=0 (bypass).
  - Else: rd_data_j=regs[a] and rd_busy_j=busy[a].
- Same-cycle alloc does not affect rd_busy until the following cycle.
- Reset: on posedge with rst=1, all regs are cleared to 0 and all busy bits to 0. Writes and allocs in that cycle are ignored. Bypass is disabled while rst=1.
- Reset arriving mid-operation discards all pending writes, allocs and busy state with no residue.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write-to-read latency is 0 cycles via bypass; the value is architecturally visible from the array on the following cycle.
- Alloc-to-busy latency is 1 cycle.
- Output values after reset: every rd_data = 0 and every rd_busy = 0 for any address, until the first write or alloc.
- There is no handshake; the block never stalls. wr_en/alloc_en are single-cycle qualifiers.

## Structure
- Shared package (regfile_pkg): the BITS/clog2 helper, the default WordLen/WordCount/NR/NW constants, and an unpack-slice helper for packed port buses.
- One sub-module, regfile_bypass_mux: one read port's address-0 check, write-hit priority selection and busy masking. Instantiate it NR times via generate.
- The top level holds the array, the busy vector and the write-priority loop.

## Test plan
- Reset: write regs 1–31 with nonzero data, assert rst one cycle → all ports read 0, rd_busy=0; a write issued in the rst cycle is lost.
- Bypass: in the same cycle, wr_en[0]=1, wr_addr=5, wr_data=0xDEADBEEF with rd_addr0=5 → rd_data0=0xDEADBEEF that cycle; next cycle reads it from the array.
- Conflict: port0 writes r7=0x11 and port1 writes r7=0x22 in the same cycle → bypass returns 0x22, and r7=0x22 afterwards.
- Register 0: write 0xFFFFFFFF to r0 and alloc r0 → reads 0, rd_busy=0, on every port.
- Scoreboard: alloc r9 → rd_busy=1 next cycle. Write r9 with 0x42 → rd_busy=0 in the write cycle (bypass) and after. Alloc and write r9 in the same cycle → rd_busy=1 the cycle after, and data=new value.
- Parameter sweep: WordLen=16, WordCount=8, NR=4, NW=3 with random writes/reads against a reference model → zero mismatches over 10k cycles.
